// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the MIPS32 memory arbiter slice.
// Contents: default address/data widths, arbiter FSM state encoding and
// the owner encoding recorded for the access in flight.
package mips32_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for arbiters.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   inc_i    - count one bypass of the starved requester (saturates at MAX)
//   clr_i    - clear the count (wins over inc_i)
//   at_max_o - count has reached MAX
module arb_starve_ctr #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear has priority, increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + ONE_V;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbiter sequencing the shared word memory between instruction fetch (IF)
// and the MEM-stage data port (DM). One transaction in flight at a time;
// data wins unless IF has been bypassed STARVE_MAX times in a row.
// Ports:
//   clk1, rst_n                      - clock / async active-low reset
//   halted                           - pipeline halted, masks if_req
//   if_req/if_addr                   - IF request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata        - IF grant pulse, data-valid pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata    - data request (held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata        - data grant pulse, response pulse, data
//   mem_en/mem_we/mem_addr/mem_wdata - one-cycle memory strobe and payload
//   mem_rdata                        - read data, valid MEM_LAT after mem_en
//   busy                             - FSM not in IDLE
// All outputs come straight from flops.
module mips32_mem_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              halted,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] LAT_V = 3'(MEM_LAT);

    arb_state_e        state_q;
    arb_owner_e        owner_q;
    logic              we_q;
    logic [2:0]        lat_q;
    logic              if_gnt_q;
    logic              dm_gnt_q;
    logic              if_rvalid_q;
    logic              dm_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              busy_q;

    logic              eff_if_s;
    logic              starve_max_s;
    logic              if_win_d;
    logic              dm_win_d;
    logic              starve_inc_s;
    logic              starve_clr_s;

    assign eff_if_s = if_req & ~halted;

    // Arbitration, evaluated only while IDLE.
    always_comb begin
        if_win_d = 1'b0;
        dm_win_d = 1'b0;
        if (state_q == IDLE) begin
            if (dm_req && eff_if_s && starve_max_s) begin
                if_win_d = 1'b1;
            end else if (dm_req) begin
                dm_win_d = 1'b1;
            end else if (eff_if_s) begin
                if_win_d = 1'b1;
            end else begin
                if_win_d = 1'b0;
                dm_win_d = 1'b0;
            end
        end else begin
            if_win_d = 1'b0;
            dm_win_d = 1'b0;
        end
    end

    // A DM grant bypasses IF only if IF was actually asking; any IDLE cycle
    // without a live IF request means IF is not being starved.
    assign starve_inc_s = dm_win_d & eff_if_s;
    assign starve_clr_s = if_win_d | ((state_q == IDLE) & ~eff_if_s);

    arb_starve_ctr #(
        .WIDTH (3),
        .MAX   (STARVE_MAX)
    ) u_starve (
        .clk_i    (clk1),
        .rst_ni   (rst_n),
        .inc_i    (starve_inc_s),
        .clr_i    (starve_clr_s),
        .at_max_o (starve_max_s)
    );

    // Arbiter FSM with all registered outputs.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            lat_q       <= 3'd0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            // Pulses default low; payload registers hold.
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dm_win_d) begin
                        state_q     <= ACCESS;
                        owner_q     <= OWN_DM;
                        we_q        <= dm_we;
                        lat_q       <= 3'd0;
                        dm_gnt_q    <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                        busy_q      <= 1'b1;
                    end else if (if_win_d) begin
                        state_q     <= ACCESS;
                        owner_q     <= OWN_IF;
                        we_q        <= 1'b0;
                        lat_q       <= 3'd0;
                        if_gnt_q    <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ACCESS: begin
                    // lat_q is 0 in the strobe cycle, so mem_rdata is valid
                    // when it reaches MEM_LAT.
                    if (lat_q == LAT_V) begin
                        state_q <= RESP;
                        if (owner_q == OWN_DM) begin
                            dm_rvalid_q <= 1'b1;
                            dm_rdata_q  <= we_q ? '0 : mem_rdata;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata;
                        end
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
